if_id_queue: RTL and testbench

//  Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry FIFO of
//  {instruction, NPC} pairs between the IF stage and the ID stage. Decouples fetch from decode

---
 rtl/pipeline_pkg.sv | 12 +
 rtl/if_id_queue_mem.sv | 27 ++
 rtl/if_id_queue.sv | 111 +++++++++++
 tb/tb_if_id_queue.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: default datapath width, the NOP encoding and the IF->ID entry layout.
package pipeline_pkg;

    localparam int unsigned PIPE_XLEN = 32;
    localparam logic [PIPE_XLEN-1:0] PIPE_NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [PIPE_XLEN-1:0] instr;
        logic [PIPE_XLEN-1:0] npc;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage for the IF/ID queue: one synchronous write port and one asynchronous read port.
// The data array is deliberately unreset; validity is tracked by the owner's count.
module if_id_queue_mem
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 2 * PIPE_XLEN
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry FIFO of {instruction, NPC} between IF and ID with kill and NOP substitution.
// Optional IF_ID_BYPASS_EN: an empty queue forwards the pushed entry to ID in the same cycle.
module if_id_queue
    import pipeline_pkg::*;
#(
    parameter int unsigned     XLEN      = PIPE_XLEN,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(PIPE_NOP_INSTR)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [XLEN-1:0]            Instruction_F,
    input  logic [XLEN-1:0]            NPC_F,
    input  logic                       pop,
    input  logic                       kill,
    output logic [XLEN-1:0]            Instruction_D,
    output logic [XLEN-1:0]            NPC_D,
    output logic                       valid_D,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic [2*XLEN-1:0] w_rdata;
    logic              w_full;
    logic              w_empty;
    logic              w_byp;
    logic              w_valid;
    logic              w_pop_eff;
    logic              w_push_acc;
    logic              w_we;
    logic              w_rd_adv;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

`ifdef IF_ID_BYPASS_EN
    assign w_byp = w_empty && push && !kill;
`else
    assign w_byp = 1'b0;
`endif

    assign w_valid    = !w_empty || w_byp;
    assign w_pop_eff  = pop && w_valid;
    assign w_push_acc = push && !kill && (!w_full || w_pop_eff);
    // A bypassed entry consumed the same cycle never touches storage or the read pointer.
    assign w_we       = w_push_acc && !(w_byp && pop);
    assign w_rd_adv   = w_pop_eff && !w_byp;

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .W     (2 * XLEN)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata ({Instruction_F, NPC_F}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (kill) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_we) - CW'(w_rd_adv);
            if (push && w_full && !w_pop_eff) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        Instruction_D = NOP_INSTR;
        NPC_D         = '0;
        if (w_byp) begin
            Instruction_D = Instruction_F;
            NPC_D         = NPC_F;
        end else if (w_valid) begin
            Instruction_D = w_rdata[2*XLEN-1:XLEN];
            NPC_D         = w_rdata[XLEN-1:0];
        end
    end

    assign valid_D  = w_valid;
    assign full     = w_full;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH=4); the bypass case runs when IF_ID_BYPASS_EN is defined.
module tb_if_id_queue;

    logic        clk;
    logic        reset;
    logic        push;
    logic [31:0] Instruction_F;
    logic [31:0] NPC_F;
    logic        pop;
    logic        kill;
    logic [31:0] Instruction_D;
    logic [31:0] NPC_D;
    logic        valid_D;
    logic        full;
    logic [2:0]  count;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    if_id_queue #(
        .XLEN      (32),
        .DEPTH     (4),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .Instruction_F (Instruction_F),
        .NPC_F         (NPC_F),
        .pop           (pop),
        .kill          (kill),
        .Instruction_D (Instruction_D),
        .NPC_D         (NPC_D),
        .valid_D       (valid_D),
        .full          (full),
        .count         (count),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, cross the edge, then return the inputs to idle.
    task automatic step(input logic p, input logic [31:0] ins, input logic [31:0] npc,
                        input logic po, input logic k);
        push          = p;
        Instruction_F = ins;
        NPC_F         = npc;
        pop           = po;
        kill          = k;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        kill = 1'b0;
    endtask

    task automatic drain_check(input string tag, input logic [31:0] exp0, input logic [31:0] exp1,
                               input logic [31:0] exp2, input logic [31:0] exp3);
        logic [31:0] exp [4];
        exp[0] = exp0; exp[1] = exp1; exp[2] = exp2; exp[3] = exp3;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_head%0d", tag, k), Instruction_D, exp[k]);
            check($sformatf("%s_valid%0d", tag, k), 32'(valid_D), 32'd1);
            step(1'b0, '0, '0, 1'b1, 1'b0);
        end
        check({tag, "_empty_valid"}, 32'(valid_D), 32'd0);
        check({tag, "_empty_nop"}, Instruction_D, 32'h0000_0000);
        check({tag, "_empty_count"}, 32'(count), 32'd0);
    endtask

    initial begin
        reset         = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        kill          = 1'b0;
        Instruction_F = '0;
        NPC_F         = '0;
        #2;
        check("rst_valid", 32'(valid_D), 32'd0);
        check("rst_instr", Instruction_D, 32'h0000_0000);
        check("rst_npc", NPC_D, 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        #10 reset = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: latency and ordering of the first two pushes
        push = 1'b1; Instruction_F = 32'hAAAA_AAAA; NPC_F = 32'd1;
        #1;
`ifndef IF_ID_BYPASS_EN
        check("t1_same_cycle_valid", 32'(valid_D), 32'd0);
        check("t1_same_cycle_nop", Instruction_D, 32'h0000_0000);
`endif
        @(posedge clk);
        #1;
        push = 1'b0;
        check("t1_head", Instruction_D, 32'hAAAA_AAAA);
        check("t1_npc", NPC_D, 32'd1);
        check("t1_valid", 32'(valid_D), 32'd1);
        step(1'b1, 32'hBBBB_BBBB, 32'd2, 1'b0, 1'b0);
        check("t1_count", 32'(count), 32'd2);
        check("t1_head_kept", Instruction_D, 32'hAAAA_AAAA);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("t1_second", Instruction_D, 32'hBBBB_BBBB);
        check("t1_second_npc", NPC_D, 32'd2);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("t1_drained", 32'(count), 32'd0);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("t1_pop_empty_count", 32'(count), 32'd0);

        // Test 2: fill, overflow drop, drain in order
        for (int k = 1; k <= 4; k++) step(1'b1, 32'(k * 32'h11), 32'(k), 1'b0, 1'b0);
        check("t2_full", 32'(full), 32'd1);
        check("t2_count", 32'(count), 32'd4);
        check("t2_ovf_before", 32'(overflow), 32'd0);
        step(1'b1, 32'h55, 32'd5, 1'b0, 1'b0);
        check("t2_ovf", 32'(overflow), 32'd1);
        check("t2_count_after_drop", 32'(count), 32'd4);
        drain_check("t2", 32'h11, 32'h22, 32'h33, 32'h44);
        check("t2_full_cleared", 32'(full), 32'd0);

        // Test 3: push+pop on full keeps count at DEPTH
        for (int k = 1; k <= 4; k++) step(1'b1, 32'(k * 32'h11), 32'(k), 1'b0, 1'b0);
        step(1'b1, 32'h66, 32'd6, 1'b1, 1'b0);
        check("t3_count", 32'(count), 32'd4);
        check("t3_full", 32'(full), 32'd1);
        drain_check("t3", 32'h22, 32'h33, 32'h44, 32'h66);

        // Test 4: kill beats a same-cycle push
        for (int k = 1; k <= 3; k++) step(1'b1, 32'hA0 + 32'(k), 32'(k), 1'b0, 1'b0);
        check("t4_count3", 32'(count), 32'd3);
        step(1'b1, 32'hCCCC_CCCC, 32'd9, 1'b0, 1'b1);
        check("t4_count", 32'(count), 32'd0);
        check("t4_valid", 32'(valid_D), 32'd0);
        check("t4_nop", Instruction_D, 32'h0000_0000);
        check("t4_npc", NPC_D, 32'd0);
        check("t4_ovf_kept", 32'(overflow), 32'd1);
        step(1'b1, 32'hE1E1_E1E1, 32'd11, 1'b0, 1'b0);
        check("t4_after_kill_head", Instruction_D, 32'hE1E1_E1E1);
        check("t4_after_kill_count", 32'(count), 32'd1);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("t4_no_cccc", 32'(valid_D), 32'd0);

        // Test 5: alternating push/pop wraps the pointers
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 32'h1000 + 32'(k), 32'h2000 + 32'(k), 1'b0, 1'b0);
            check($sformatf("t5_head%0d", k), Instruction_D, 32'h1000 + 32'(k));
            check($sformatf("t5_npc%0d", k), NPC_D, 32'h2000 + 32'(k));
            check($sformatf("t5_count%0d", k), 32'(count), 32'd1);
            step(1'b0, '0, '0, 1'b1, 1'b0);
            check($sformatf("t5_empty%0d", k), 32'(count), 32'd0);
        end

        // Test 6: asynchronous reset mid-cycle
        for (int k = 1; k <= 3; k++) step(1'b1, 32'hB0 + 32'(k), 32'(k), 1'b0, 1'b0);
        check("t6_count3", 32'(count), 32'd3);
        #2 reset = 1'b0;
        #1;
        check("t6_async_count", 32'(count), 32'd0);
        check("t6_async_valid", 32'(valid_D), 32'd0);
        check("t6_async_nop", Instruction_D, 32'h0000_0000);
        check("t6_async_ovf", 32'(overflow), 32'd0);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check("t6_post_count", 32'(count), 32'd0);
        check("t6_post_valid", 32'(valid_D), 32'd0);

`ifdef IF_ID_BYPASS_EN
        // Bypass: empty queue forwards same cycle
        push = 1'b1; Instruction_F = 32'hDDDD_DDDD; NPC_F = 32'd13; pop = 1'b1;
        #1;
        check("byp_instr", Instruction_D, 32'hDDDD_DDDD);
        check("byp_npc", NPC_D, 32'd13);
        check("byp_valid", 32'(valid_D), 32'd1);
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0;
        check("byp_count", 32'(count), 32'd0);
        check("byp_after_valid", 32'(valid_D), 32'd0);
        step(1'b1, 32'hDEAD_0001, 32'd14, 1'b0, 1'b0);
        check("byp_nopop_count", 32'(count), 32'd1);
        check("byp_nopop_head", Instruction_D, 32'hDEAD_0001);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
